// File: rtl/stream_demux4.sv
// 1-to-4 valid/ready packet demultiplexer with a one-entry output register per channel.
// Optional clocked checks are compiled in when STREAM_DEMUX4_ASSERT_EN is defined.
module stream_demux4 #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_sel,
    input  logic                in_last,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic [3:0]          out_last,
    output logic                busy,
    output logic [1:0]          cur_sel
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t             state_reg;
    logic [1:0]         lock_sel_reg;
    logic               busy_reg;
    logic [1:0]         route;
    logic               accept;
    logic [3:0]         valid_reg;
    logic [3:0]         last_reg;
    logic [DATA_W-1:0]  data_reg [4];

    // The first beat of a packet is steered by in_sel directly; later beats use the lock.
    assign route    = (state_reg == IDLE) ? in_sel : lock_sel_reg;
    assign in_ready = !valid_reg[route] || out_ready[route];
    assign accept   = in_valid && in_ready;

    assign cur_sel   = route;
    assign busy      = busy_reg;
    assign out_valid = valid_reg;
    assign out_last  = last_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            lock_sel_reg <= 2'd0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept && !in_last) begin
                        lock_sel_reg <= in_sel;
                        state_reg    <= PKT;
                        busy_reg     <= 1'b1;
                    end
                end
                PKT: begin
                    if (accept && in_last) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            // A load in the same cycle as a drain takes priority, keeping 1 beat/cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    last_reg[gi]  <= 1'b0;
                    data_reg[gi]  <= '0;
                end else if (accept && (route == 2'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                    last_reg[gi]  <= in_last;
                    data_reg[gi]  <= in_data;
                end else if (out_ready[gi]) begin
                    valid_reg[gi] <= 1'b0;
                end
            end
            assign out_data[gi*DATA_W +: DATA_W] = data_reg[gi];
        end
    endgenerate

`ifdef STREAM_DEMUX4_ASSERT_EN
    logic [3:0]        hold_reg;
    logic [3:0]        plast_reg;
    logic [DATA_W-1:0] pdata_reg [4];
    logic              acc_reg;
    logic [1:0]        proute_reg;
    logic              blocked_reg;
    logic              prst_reg;

    always_ff @(posedge clk) begin
        prst_reg    <= rst;
        acc_reg     <= accept;
        proute_reg  <= route;
        blocked_reg <= in_valid && !in_ready;
        hold_reg    <= valid_reg & ~out_ready;
        plast_reg   <= last_reg;
        pdata_reg   <= data_reg;
    end

    // Previous-cycle snapshot versus current registers; skipped around reset.
    always @(posedge clk) begin
        if (!rst && !prst_reg) begin
            for (int i = 0; i < 4; i++) begin
                if (hold_reg[i])
                    assert (data_reg[i] == pdata_reg[i] && last_reg[i] == plast_reg[i])
                    else $error("%0t: channel %0d payload changed while stalled", $time, i);
                if (blocked_reg)
                    assert (data_reg[i] == pdata_reg[i] && last_reg[i] == plast_reg[i])
                    else $error("%0t: channel %0d changed without an accept", $time, i);
            end
            if (acc_reg)
                assert (valid_reg[proute_reg])
                else $error("%0t: accept to channel %0d not visible", $time, proute_reg);
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Directed bench for stream_demux4: reset, routing, route lock, backpressure, stall isolation.
module tb_stream_demux4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_last;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_last;
    logic        busy;
    logic [1:0]  cur_sel;

    int total = 0;
    int bad   = 0;

    stream_demux4 #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .cur_sel(cur_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] chd(input int i);
        return 32'(out_data[i*8 +: 8]);
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sel = 2'd0;
        in_last = 1'b0; out_ready = 4'b0000;
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cursel", 32'(cur_sel), 32'h0);
        chk("rst_inready", 32'(in_ready), 32'h1);

        // single-beat packet to channel 2
        rst = 1'b0; out_ready = 4'b1111;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; in_last = 1'b1;
        step();
        in_valid = 1'b0;
        chk("sb_valid", 32'(out_valid), 32'h4);
        chk("sb_data2", chd(2), 32'hA5);
        chk("sb_last", 32'(out_last), 32'h4);
        chk("sb_busy", 32'(busy), 32'h0);
        step();
        chk("sb_drain", 32'(out_valid), 32'h0);

        // locked route: beat 0 selects channel 1, later beats try channel 3
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h10; in_last = 1'b0;
        step();
        chk("lk_valid0", 32'(out_valid), 32'h2);
        chk("lk_data0", chd(1), 32'h10);
        for (int b = 1; b < 4; b++) begin
            in_sel = 2'd3; in_data = 8'(8'h10 + b); in_last = (b == 3);
            #1;
            chk($sformatf("lk_busy%0d", b), 32'(busy), 32'h1);
            chk($sformatf("lk_cursel%0d", b), 32'(cur_sel), 32'h1);
            step();
            chk($sformatf("lk_valid%0d", b), 32'(out_valid), 32'h2);
            chk($sformatf("lk_data%0d", b), chd(1), 32'(8'h10 + b));
        end
        in_valid = 1'b0;
        chk("lk_busy_end", 32'(busy), 32'h0);
        chk("lk_last", 32'(out_last[1]), 32'h1);
        step();
        chk("lk_drain", 32'(out_valid), 32'h0);

        // backpressure on channel 0
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h20; in_last = 1'b0;
        #1;
        chk("bp_ready0", 32'(in_ready), 32'h1);
        step();
        in_data = 8'h21;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_stall_rdy%0d", c), 32'(in_ready), 32'h0);
            chk($sformatf("bp_stall_dat%0d", c), chd(0), 32'h20);
            chk($sformatf("bp_stall_vld%0d", c), 32'(out_valid), 32'h1);
            step();
        end
        out_ready = 4'b0001;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'h1);
        step();
        chk("bp_data21", chd(0), 32'h21);
        chk("bp_busy", 32'(busy), 32'h1);
        in_data = 8'h22; in_last = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_data22", chd(0), 32'h22);
        chk("bp_last", 32'(out_last[0]), 32'h1);
        chk("bp_busy_end", 32'(busy), 32'h0);
        step();
        chk("bp_drain", 32'(out_valid), 32'h0);

        // channel 3 stalled must not block a packet to channel 0
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h33; in_last = 1'b1;
        step();
        chk("is_valid3", 32'(out_valid), 32'h8);
        in_sel = 2'd0; in_data = 8'h44;
        #1;
        chk("is_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk("is_valid", 32'(out_valid), 32'h9);
        chk("is_data0", chd(0), 32'h44);
        chk("is_data3", chd(3), 32'h33);
        out_ready = 4'b1111;
        step();
        chk("is_drain", 32'(out_valid), 32'h0);

        // reset in the middle of a packet to channel 2
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h50; in_last = 1'b0;
        step();
        in_data = 8'h51;
        step();
        chk("rm_pre_busy", 32'(busy), 32'h1);
        chk("rm_pre_data", chd(2), 32'h51);
        in_valid = 1'b0; out_ready = 4'b0000; in_sel = 2'd1; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rm_valid", 32'(out_valid), 32'h0);
        chk("rm_busy", 32'(busy), 32'h0);
        chk("rm_cursel", 32'(cur_sel), 32'h1);
        out_ready = 4'b1111;
        in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h66; in_last = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rm_next_valid", 32'(out_valid), 32'h8);
        chk("rm_next_data", chd(3), 32'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux4.md
Name: stream_demux4

Overview:
- 1-to-4 packet demultiplexer for valid/ready streams; the output-side counterpart of the 4:1 select mux.
- Routes each incoming packet to one of four output channels, chosen by in_sel on the packet's first beat.
- The route is locked until the beat carrying in_last.
- Each channel has a one-entry output register, so the four consumers stall independently.

Parameters:
- DATA_W, 8, payload width in bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  DATA_W  input payload.
- in_sel  input  2  destination channel; sampled only on the first beat of a packet.
- in_last  input  1  final beat of the packet.
- out_valid  output  4  per-channel valid; bit i belongs to channel i.
- out_ready  input  4  per-channel ready.
- out_data  output  4*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- out_last  output  4  per-channel last flag.
- busy  output  1  high while a packet is in progress (state PKT).
- cur_sel  output  2  locked route; equals in_sel while in IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, lock_sel=0.
  - out_valid=4'b0000, out_data=0, out_last=0, busy=0.
  - Reset mid-packet discards the packet and all buffered beats; no partial flush.
- route = (state==IDLE) ? in_sel : lock_sel. Combinational.
- in_ready = !out_valid[route] || out_ready[route]. Combinational; no dependency on in_valid.
- Accept (in_valid && in_ready):
  - Channel route loads data and last at the next edge; out_valid[route]=1.
  - Latency is one cycle from accept to out_valid.
- FSM:
  - IDLE: an accept with in_last=0 sets lock_sel<=in_sel and moves to PKT. An accept with in_last=1 is a single-beat packet and stays in IDLE.
  - PKT: in_sel is ignored. An accept with in_last=1 moves to IDLE. Otherwise stay in PKT.
- Channel i drain: out_valid[i] && out_ready[i] clears out_valid[i] at the next edge, unless a new beat loads channel i in the same cycle, in which case the register holds the new beat and out_valid stays 1.
  - Full throughput of 1 beat/cycle when out_ready[route]=1.
- Stability: while out_valid[i] && !out_ready[i], out_data[i] and out_last[i] hold unchanged.
- Independence:
  - At most one channel loads per cycle.
  - Non-routed channels drain freely, concurrently with loads to another channel.
  - A stalled channel never blocks packets going to other channels once the current packet has ended.
- Boundaries:
  - Routed channel full with out_ready=0: in_ready=0 and no beat is lost.
  - in_sel changing mid-packet has no effect.
  - in_valid=0 in PKT: state and lock_sel hold.
  - busy=1 exactly in state PKT.

Optional Feature:
- Macro: STREAM_DEMUX4_ASSERT_EN.
- When defined, the block contains clocked immediate assertions, each with an $error reporting $time, checking:
  - $onehot0(out_valid) is NOT required; multiple channels may be valid simultaneously, so no check on it.
  - Payload stability: out_valid[i] && !out_ready[i] in cycle N implies identical out_data[i] and out_last[i] in cycle N+1.
  - Accept-to-valid: an accept to channel k implies out_valid[k]=1 in the next cycle.
  - No accept while in_ready=0 ever changes channel state.
  - All are gated off while rst=1.
- When undefined, no assertion code is compiled and functional behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles mid-stream → out_valid=0000, busy=0, cur_sel=0, in_ready=1.
- Single-beat routing: in_sel=2, data=0xA5, last=1, all out_ready=1 → next cycle out_valid=0100, channel-2 data=0xA5, out_last[2]=1, busy=0.
- Locked route: 4-beat packet 0x10..0x13 with in_sel=1 on beat 0, then in_sel=3 on beats 1–3 → all four beats appear on channel 1 in order, busy=1 for beats 1–3, cur_sel=1.
- Backpressure: route to channel 0 with out_ready[0]=0 for 5 cycles → in_ready=0 after the first beat, channel-0 data held constant, no beat lost; releasing ready yields 1 beat/cycle.
- Independent stall: channel 3 holds a beat with out_ready[3]=0; next packet with in_sel=0 → accepted, appears on channel 0 while channel 3 stays valid.
- Reset mid-packet: rst pulsed after beat 2 of a 4-beat packet to channel 2 → state IDLE, out_valid=0000; the next packet with in_sel=3 is routed to channel 3.
